// File: rtl/xentry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xentry_pkg
// Brief    : Shared memory-operation enums and data-cache FSM state encoding.
// Revision : 1.0 - initial set-associative data cache support
// ============================================================================
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        STORE   = 2'd1,
        CLFLUSH = 2'd2
    } memory_operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        FLUSH_WB  = 2'd3
    } dcache_assoc_state_e;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input memory_operation_size_e s);
        case (s)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
// Module   : plru_tree
// Brief    : Tree pseudo-LRU: picks a victim way from one set's PLRU bits and
//            computes the bits that make a given way most recently used.
// Revision : 1.0 - initial
// ============================================================================
module plru_tree #(
    parameter int WAYS   = 2,
    parameter int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] plru_i,
    input  logic [WAY_W-1:0]  hit_way_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [PLRU_W-1:0] plru_next_o
);

    generate
        if (WAYS == 1) begin : g_direct
            // A single way is always both the victim and the MRU way.
            logic w_unused_hit;
            assign w_unused_hit = ^hit_way_i;
            assign victim_o     = '0;
            assign plru_next_o  = plru_i;
        end else begin : g_tree
            localparam int LVL = $clog2(WAYS);
            // Heap-ordered nodes; each bit points toward the less recently used half.
            always_comb begin
                int node;
                victim_o    = '0;
                plru_next_o = plru_i;
                node        = 0;
                for (int l = 0; l < LVL; l++) begin
                    victim_o[LVL-1-l] = plru_i[node];
                    node = 2 * node + 1 + int'(plru_i[node]);
                end
                node = 0;
                for (int l = 0; l < LVL; l++) begin
                    plru_next_o[node] = ~hit_way_i[LVL-1-l];
                    node = 2 * node + 1 + int'(hit_way_i[LVL-1-l]);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dcache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : dcache_assoc
// Brief    : N-way set-associative write-back, write-allocate data cache with
//            tree-PLRU replacement and per-line flush. Whole lines move to/from
//            L2 one word per handshake. Assumes SETS >= 2 and >= 2 words/line.
// Revision : 1.0 - initial
// ============================================================================
module dcache_assoc
    import xentry_pkg::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int XLEN       = 32,
    parameter int WAYS       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        pipe_req_address,
    input  memory_operation_size_e pipe_req_size,
    input  memory_operation_e      pipe_req_type,
    input  logic                   pipe_req_valid,
    input  logic [XLEN-1:0]        pipe_word_to_store,
    output logic [XLEN-1:0]        pipe_fetched_word,
    output logic                   pipe_req_fulfilled,
    output logic [XLEN-1:0]        l2_req_address,
    output memory_operation_e      l2_req_type,
    output logic                   l2_req_valid,
    output logic [XLEN-1:0]        l2_word_to_store,
    input  logic [XLEN-1:0]        l2_fetched_word,
    input  logic                   l2_req_fulfilled
);

    localparam int WB_BYTES = XLEN / 8;
    localparam int WORDS    = LINE_SIZE / WB_BYTES;
    localparam int SETS     = CACHE_SIZE / (LINE_SIZE * WAYS);
    localparam int OFF_W    = $clog2(LINE_SIZE);
    localparam int IDX_W    = $clog2(SETS);
    localparam int BO_W     = $clog2(WB_BYTES);
    localparam int WO_W     = $clog2(WORDS);
    localparam int TAG_W    = XLEN - OFF_W - IDX_W;
    localparam int LINE_W   = XLEN - OFF_W;
    localparam int CNT_W    = $clog2(WORDS + 1);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;

    // Control state; the miss target line and way are latched so a dropped
    // request cannot disturb an in-flight line transfer.
    dcache_assoc_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [LINE_W-1:0]   line_q, line_d;

    // Line storage (flops).
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];
    logic [PLRU_W-1:0] plru_q  [SETS];
    logic [TAG_W-1:0]  tags_q  [WAYS][SETS];
    logic [XLEN-1:0]   data_q  [WAYS][SETS][WORDS];

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx, w_line_idx;
    logic [TAG_W-1:0]  w_line_tag;
    logic [WO_W-1:0]   w_word, w_xfer_word;
    logic [BO_W-1:0]   w_boff, w_aoff;
    logic              w_hit, w_inv_any, w_hit_dirty, w_vict_dirty, w_is_access, w_last;
    logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_plru_victim, w_victim;
    logic [PLRU_W-1:0] w_plru_next;
    logic [2:0]        w_nbytes;
    logic [WB_BYTES-1:0] w_be;
    logic [XLEN-1:0]   w_st_shift, w_merged, w_ld_word, w_ld_shift, w_ld_mask;

    assign w_tag        = pipe_req_address[XLEN-1 -: TAG_W];
    assign w_idx        = pipe_req_address[OFF_W +: IDX_W];
    assign w_word       = pipe_req_address[BO_W +: WO_W];
    assign w_boff       = pipe_req_address[BO_W-1:0];
    assign w_line_idx   = line_q[IDX_W-1:0];
    assign w_line_tag   = line_q[LINE_W-1:IDX_W];
    assign w_xfer_word  = WO_W'(CNT_W'(WORDS) - cnt_q);
    assign w_last       = (cnt_q == CNT_W'(1));
    assign w_is_access  = (pipe_req_type == LOAD) || (pipe_req_type == STORE);
    assign w_hit_dirty  = dirty_q[w_hit_way][w_idx];
    assign w_victim     = w_inv_any ? w_inv_way : w_plru_victim;
    assign w_vict_dirty = dirty_q[w_victim][w_idx];

    // Compare all ways; descending scan leaves the lowest matching index.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][w_idx] && (tags_q[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!valid_q[w][w_idx]) begin
                w_inv_any = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    plru_tree #(
        .WAYS   (WAYS),
        .WAY_W  (WAY_W),
        .PLRU_W (PLRU_W)
    ) u_plru (
        .plru_i      (plru_q[w_idx]),
        .hit_way_i   (w_hit_way),
        .victim_o    (w_plru_victim),
        .plru_next_o (w_plru_next)
    );

    // Byte-lane alignment for loads and stores; size-misaligned low bits dropped.
    always_comb begin
        w_nbytes   = size_bytes(pipe_req_size);
        w_aoff     = w_boff & ~BO_W'(w_nbytes - 3'd1);
        w_be       = WB_BYTES'((32'd1 << w_nbytes) - 32'd1) << w_aoff;
        w_st_shift = pipe_word_to_store << {w_aoff, 3'b000};
        w_ld_word  = data_q[w_hit_way][w_idx][w_word];
        w_ld_shift = w_ld_word >> {w_aoff, 3'b000};
        w_ld_mask  = {XLEN{1'b1}} >> (XLEN - 8 * int'(w_nbytes));
        w_merged   = w_ld_word;
        for (int b = 0; b < WB_BYTES; b++) begin
            if (w_be[b]) begin
                w_merged[8*b +: 8] = w_st_shift[8*b +: 8];
            end
        end
    end

    // State register, transfer counter and latched miss target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            way_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
            line_q  <= line_d;
        end
    end

    // Next-state: misses start writeback or fill, dirty flush starts FLUSH_WB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        way_d   = way_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (pipe_req_valid && w_is_access && !w_hit) begin
                    way_d   = w_victim;
                    line_d  = pipe_req_address[XLEN-1:OFF_W];
                    cnt_d   = CNT_W'(WORDS);
                    state_d = w_vict_dirty ? WRITEBACK : FILL;
                end else if (pipe_req_valid && (pipe_req_type == CLFLUSH) && w_hit && w_hit_dirty) begin
                    way_d   = w_hit_way;
                    line_d  = pipe_req_address[XLEN-1:OFF_W];
                    cnt_d   = CNT_W'(WORDS);
                    state_d = FLUSH_WB;
                end
            end
            WRITEBACK: begin
                if (l2_req_fulfilled) begin
                    if (w_last) begin
                        cnt_d   = CNT_W'(WORDS);
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FILL, FLUSH_WB: begin
                if (l2_req_fulfilled) begin
                    if (w_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pipe responses in IDLE, one L2 word per state-held request otherwise.
    always_comb begin
        pipe_req_fulfilled = 1'b0;
        pipe_fetched_word  = '0;
        l2_req_valid       = 1'b0;
        l2_req_type        = LOAD;
        l2_req_address     = '0;
        l2_word_to_store   = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (pipe_req_valid) begin
                        if (pipe_req_type == CLFLUSH) begin
                            // A dirty hit finishes after FLUSH_WB, when it misses here.
                            pipe_req_fulfilled = !(w_hit && w_hit_dirty);
                        end else if (w_is_access && w_hit) begin
                            pipe_req_fulfilled = 1'b1;
                            if (pipe_req_type == LOAD) begin
                                pipe_fetched_word = w_ld_shift & w_ld_mask;
                            end
                        end
                    end
                end
                WRITEBACK, FLUSH_WB: begin
                    l2_req_valid     = 1'b1;
                    l2_req_type      = STORE;
                    l2_req_address   = {tags_q[way_q][w_line_idx], w_line_idx, w_xfer_word, {BO_W{1'b0}}};
                    l2_word_to_store = data_q[way_q][w_line_idx][w_xfer_word];
                end
                FILL: begin
                    l2_req_valid   = 1'b1;
                    l2_req_type    = LOAD;
                    l2_req_address = {line_q, w_xfer_word, {BO_W{1'b0}}};
                end
                default: ;
            endcase
        end
    end

    // Valid/dirty/PLRU bookkeeping; PLRU moves only on LOAD/STORE hits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (pipe_req_valid && w_hit) begin
                        if (w_is_access) begin
                            plru_q[w_idx] <= w_plru_next;
                        end
                        if (pipe_req_type == STORE) begin
                            dirty_q[w_hit_way][w_idx] <= 1'b1;
                        end
                        if ((pipe_req_type == CLFLUSH) && !w_hit_dirty) begin
                            valid_q[w_hit_way][w_idx] <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (l2_req_fulfilled && w_last) begin
                        valid_q[way_q][w_line_idx] <= 1'b1;
                        dirty_q[way_q][w_line_idx] <= 1'b0;
                    end
                end
                FLUSH_WB: begin
                    if (l2_req_fulfilled && w_last) begin
                        valid_q[way_q][w_line_idx] <= 1'b0;
                        dirty_q[way_q][w_line_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: store-hit byte merge and fill word capture.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && pipe_req_valid && (pipe_req_type == STORE) && w_hit) begin
            data_q[w_hit_way][w_idx][w_word] <= w_merged;
        end
        if ((state_q == FILL) && l2_req_fulfilled) begin
            data_q[way_q][w_line_idx][w_xfer_word] <= l2_fetched_word;
            if (w_last) begin
                tags_q[way_q][w_line_idx] <= w_line_tag;
            end
        end
    end

endmodule
`default_nettype wire
